// File: rtl/ex_redirect_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_redirect_if
//  Description : EX-to-fetch redirect bundle. Carries the resolved jump/branch
//                decision and targets from the EX branch unit, and the
//                redirect valid/ready handshake towards the fetch PC mux.
//                The slave modport is the redirect controller; the master
//                modport is the surrounding pipeline (EX unit plus fetch).
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_redirect_if #(
   parameter int XLEN = 64
) ();

   // EX branch unit results
   logic            i_ex_valid;
   logic            i_ex_jump_taken;
   logic            i_ex_branch_taken;
   logic [XLEN-1:0] i_ex_jump_target;
   logic [XLEN-1:0] i_ex_branch_target;

   // Redirect handshake with fetch
   logic            i_fetch_ready;
   logic            o_redirect_valid;
   logic [XLEN-1:0] o_redirect_pc;

   // Pipeline side: drives EX results and fetch ready, observes the redirect
   modport master (
      output i_ex_valid,
      output i_ex_jump_taken,
      output i_ex_branch_taken,
      output i_ex_jump_target,
      output i_ex_branch_target,
      output i_fetch_ready,
      input  o_redirect_valid,
      input  o_redirect_pc
   );

   // Redirect controller side
   modport slave (
      input  i_ex_valid,
      input  i_ex_jump_taken,
      input  i_ex_branch_taken,
      input  i_ex_jump_target,
      input  i_ex_branch_target,
      input  i_fetch_ready,
      output o_redirect_valid,
      output o_redirect_pc
   );

endinterface : ex_redirect_if
`default_nettype wire

// File: rtl/ex_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ex_redirect_ctrl
//  Description : Execute-stage control-flow redirect sequencer. Captures one
//                taken jump/branch while idle, presents the aligned target to
//                fetch until it is accepted, then keeps the front-end flush
//                asserted for FLUSH_CYCLES further cycles so the wrong-path
//                instructions in IF/ID/EX are squashed. Counts accepted
//                redirects in a wrapping event counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_redirect_ctrl #(
   parameter int XLEN         = 64,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_stall,
   ex_redirect_if.slave          bus,
   output logic                  o_flush,
   output logic                  o_busy,
   output logic [CNT_W-1:0]      o_redirect_cnt
);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // -------------------------------------------------------------------------
   generate
      if ((FLUSH_CYCLES < 0) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
         $error("ex_redirect_ctrl: FLUSH_CYCLES must be within 0..15");
      end
      if (XLEN < 2) begin : g_bad_xlen
         $error("ex_redirect_ctrl: XLEN must be at least 2");
      end
      if (CNT_W < 1) begin : g_bad_cnt_w
         $error("ex_redirect_ctrl: CNT_W must be at least 1");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   // A zero-length flush skips the FLUSH state entirely after the handshake.
   localparam bit        c_HAS_FLUSH  = (FLUSH_CYCLES > 0);
   // The cycle right after the handshake is the first FLUSH cycle, so the
   // countdown starts one below the requested length.
   localparam logic [3:0] c_FLUSH_LOAD = 4'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);
   // Instruction targets are at least halfword aligned; bit 0 is always cleared.
   localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REDIRECT = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [XLEN-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]  r_redirect_cnt;
   logic [3:0]        r_flush_cnt;
   logic [3:0]        w_flush_cnt_nxt;

   logic              w_taken;
   logic              w_capture;
   logic              w_handshake;
   logic [XLEN-1:0]   w_target;
   logic [XLEN-1:0]   w_target_aligned;

   // -------------------------------------------------------------------------
   // Capture / handshake qualification
   // -------------------------------------------------------------------------
   // Only IDLE may capture; anything taken while a redirect is in flight is
   // on the wrong path and is simply dropped.
   assign w_taken          = bus.i_ex_jump_taken | bus.i_ex_branch_taken;
   assign w_capture        = (r_state == S_IDLE) & bus.i_ex_valid & ~i_stall & w_taken;
   assign w_handshake      = (r_state == S_REDIRECT) & bus.i_fetch_ready;

   // Jump has priority when a jump and a branch both resolve taken together.
   assign w_target         = bus.i_ex_jump_taken ? bus.i_ex_jump_target
                                                 : bus.i_ex_branch_target;
   assign w_target_aligned = w_target & c_ALIGN_MASK;

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and flush countdown; stall never freezes REDIRECT or FLUSH
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_capture) begin
               w_state_nxt = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            if (w_handshake) begin
               if (c_HAS_FLUSH) begin
                  w_state_nxt     = S_FLUSH;
                  w_flush_cnt_nxt = c_FLUSH_LOAD;
               end else begin
                  w_state_nxt     = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == 4'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   // Redirect target, accepted-redirect counter and flush countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_pc  <= '0;
         r_redirect_cnt <= '0;
         r_flush_cnt    <= 4'd0;
      end else begin
         // Target only loads on capture, so it is stable through REDIRECT
         // and keeps its last value once back in IDLE.
         if (w_capture) begin
            r_redirect_pc <= w_target_aligned;
         end
         if (w_handshake) begin
            r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
         end
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: registers or pure state decodes, no input-to-output paths
   // -------------------------------------------------------------------------
   assign bus.o_redirect_valid = (r_state == S_REDIRECT);
   assign bus.o_redirect_pc    = r_redirect_pc;
   assign o_flush              = (r_state != S_IDLE);
   assign o_busy               = (r_state != S_IDLE);
   assign o_redirect_cnt       = r_redirect_cnt;

endmodule : ex_redirect_ctrl
`default_nettype wire

// File: tb/tb_ex_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_redirect_ctrl
//  Description : Scoreboard bench for ex_redirect_ctrl. Stimulus pushes the
//                expected redirect (pc, valid length, flush length, counter)
//                into a queue; an independent monitor pops and compares at
//                every fetch handshake and at the end of every flush window.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_redirect_ctrl;

   localparam int XLEN = 64;
   localparam int FC   = 2;
   localparam int CW   = 4;

   typedef struct {
      logic [63:0]   pc;
      int            vlen;
      int            flen;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          i_stall;
   logic          o_flush;
   logic          o_busy;
   logic [CW-1:0] o_redirect_cnt;

   ex_redirect_if #(.XLEN(XLEN)) bus ();

   ex_redirect_ctrl #(
      .XLEN         (XLEN),
      .FLUSH_CYCLES (FC),
      .CNT_W        (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_stall        (i_stall),
      .bus            (bus),
      .o_flush        (o_flush),
      .o_busy         (o_busy),
      .o_redirect_cnt (o_redirect_cnt)
   );

   int            total = 0;
   int            bad   = 0;
   exp_t          sb[$];
   logic [CW-1:0] exp_cnt = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_ex();
      bus.i_ex_valid         = 1'b0;
      bus.i_ex_jump_taken    = 1'b0;
      bus.i_ex_branch_taken  = 1'b0;
      bus.i_ex_jump_target   = '0;
      bus.i_ex_branch_target = '0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_reached", 64'(o_busy), 64'd0);
   endtask

   // Called #1 after a rising edge with the controller idle.
   task automatic do_redirect(input logic jt, input logic bt,
                              input logic [63:0] jtgt, input logic [63:0] btgt,
                              input logic [63:0] exp_pc, input int delay, input bit inject);
      exp_t e;
      e.pc   = exp_pc;
      e.vlen = delay + 1;
      e.flen = delay + 1 + FC;
      e.cnt  = exp_cnt;
      sb.push_back(e);
      exp_cnt = exp_cnt + 1'b1;

      bus.i_ex_valid         = 1'b1;
      bus.i_ex_jump_taken    = jt;
      bus.i_ex_branch_taken  = bt;
      bus.i_ex_jump_target   = jtgt;
      bus.i_ex_branch_target = btgt;
      bus.i_fetch_ready      = 1'b0;
      @(posedge clk); #1;
      if (inject) begin
         // Wrong-path takens during REDIRECT and FLUSH must be ignored
         bus.i_ex_valid         = 1'b1;
         bus.i_ex_jump_taken    = 1'b0;
         bus.i_ex_branch_taken  = 1'b1;
         bus.i_ex_branch_target = 64'h5000;
      end else begin
         clear_ex();
      end
      repeat (delay) begin
         @(posedge clk); #1;
      end
      bus.i_fetch_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_fetch_ready = 1'b0;
      wait_idle();
      clear_ex();
      check("pc_hold_idle", bus.o_redirect_pc, exp_pc);
      check("cnt_after", 64'(o_redirect_cnt), 64'(exp_cnt));
      @(posedge clk); #1;
      check("no_extra_capture", 64'(o_busy), 64'd0);
   endtask

   // Monitor: compares every handshake and every flush window against the queue
   initial begin
      exp_t cur;
      int   vcnt     = 0;
      int   fcnt     = 0;
      int   flen_exp = -1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            vcnt = 0; fcnt = 0; flen_exp = -1;
            continue;
         end
         if (bus.o_redirect_valid) vcnt++;
         if (o_flush) begin
            fcnt++;
         end else if (fcnt > 0) begin
            check("flush_expected", 64'(flen_exp >= 0), 64'd1);
            if (flen_exp >= 0) check("flush_len", 64'(fcnt), 64'(flen_exp));
            check("busy_with_flush", 64'(o_busy), 64'd0);
            fcnt = 0; flen_exp = -1;
         end
         if (bus.o_redirect_valid && bus.i_fetch_ready) begin
            check("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               cur = sb.pop_front();
               check("redirect_pc", bus.o_redirect_pc, cur.pc);
               check("valid_len", 64'(vcnt), 64'(cur.vlen));
               check("cnt_at_hs", 64'(o_redirect_cnt), 64'(cur.cnt));
               flen_exp = cur.flen;
            end
            vcnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n             = 1'b0;
      i_stall           = 1'b0;
      bus.i_fetch_ready = 1'b0;
      clear_ex();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.o_redirect_valid), 64'd0);
      check("rst_pc",    bus.o_redirect_pc, 64'd0);
      check("rst_flush", 64'(o_flush), 64'd0);
      check("rst_busy",  64'(o_busy), 64'd0);
      check("rst_cnt",   64'(o_redirect_cnt), 64'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_valid", 64'(bus.o_redirect_valid), 64'd0);
      check("idle_flush", 64'(o_flush), 64'd0);
      check("idle_busy",  64'(o_busy), 64'd0);

      // Branch redirect, immediate accept
      do_redirect(1'b0, 1'b1, 64'h0, 64'h1000, 64'h1000, 0, 1'b0);
      // Jump priority and bit-0 clearing
      do_redirect(1'b1, 1'b1, 64'h2003, 64'h3000, 64'h2002, 0, 1'b0);
      // Backpressure for 4 cycles with wrong-path takens at 0x5000
      do_redirect(1'b0, 1'b1, 64'h0, 64'h4000, 64'h4000, 4, 1'b1);

      // Stall and invalid gating
      bus.i_ex_valid = 1'b1; i_stall = 1'b1;
      bus.i_ex_branch_taken = 1'b1; bus.i_ex_branch_target = 64'h9000;
      @(posedge clk); #1;
      check("stall_busy",  64'(o_busy), 64'd0);
      check("stall_valid", 64'(bus.o_redirect_valid), 64'd0);
      clear_ex(); i_stall = 1'b0;
      bus.i_ex_jump_taken = 1'b1; bus.i_ex_jump_target = 64'h9100;
      @(posedge clk); #1;
      check("novalid_busy", 64'(o_busy), 64'd0);
      check("novalid_pc",   bus.o_redirect_pc, 64'h4000);
      clear_ex();

      // Takens arriving while flushing are ignored
      do_redirect(1'b1, 1'b0, 64'h6001, 64'h0, 64'h6000, 0, 1'b1);

      // Twelve more redirects: 16 total, 4-bit counter wraps to 0
      for (int i = 0; i < 12; i++) begin
         logic [63:0] pc;
         pc = 64'h8000 + 64'(i) * 64'h10;
         do_redirect(1'b0, 1'b1, 64'h0, pc | 64'h1, pc, i % 3, 1'b0);
      end
      check("cnt_wrap", 64'(o_redirect_cnt), 64'd0);

      // One more, then reset in the middle of the next REDIRECT
      do_redirect(1'b1, 1'b0, 64'hC000, 64'h0, 64'hC000, 1, 1'b0);
      bus.i_ex_valid = 1'b1; bus.i_ex_branch_taken = 1'b1; bus.i_ex_branch_target = 64'hD000;
      @(posedge clk); #1;
      clear_ex();
      check("pre_rst_valid", 64'(bus.o_redirect_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(bus.o_redirect_valid), 64'd0);
      check("midrst_flush", 64'(o_flush), 64'd0);
      check("midrst_busy",  64'(o_busy), 64'd0);
      check("midrst_cnt",   64'(o_redirect_cnt), 64'd0);
      check("midrst_pc",    bus.o_redirect_pc, 64'd0);
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Normal operation after reset
      do_redirect(1'b0, 1'b1, 64'h0, 64'hA000, 64'hA000, 2, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ex_redirect_ctrl
`default_nettype wire

// File: doc/ex_redirect_ctrl.md
# ex_redirect_ctrl

Sequences control-flow redirects out of the execute stage. Takes the jump/branch decision and target produced by the EX branch unit, registers one redirect, and holds it until the fetch stage accepts it through a valid/ready handshake. Then holds a front-end flush for a fixed number of cycles so wrong-path instructions in IF/ID/EX are squashed. Sits between the EX branch unit and the fetch PC mux / pipeline-register flush inputs.

## Interface
- XLEN, 64, PC/target width
- FLUSH_CYCLES, 2, cycles `o_flush` stays high after the handshake; legal range 0..15
- CNT_W, 32, width of the redirect event counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_ex_valid  in  1  EX instruction valid (struct `is_valid`)
- i_stall  in  1  pipeline stall; no capture while high
- i_ex_jump_taken  in  1  jump (JAL/JALR) resolved taken
- i_ex_branch_taken  in  1  conditional branch resolved taken
- i_ex_jump_target  in  XLEN  jump target
- i_ex_branch_target  in  XLEN  branch target
- i_fetch_ready  in  1  fetch accepts the redirect this cycle
- o_redirect_valid  out  1  redirect pending to fetch
- o_redirect_pc  out  XLEN  redirect target, bit 0 forced 0
- o_flush  out  1  squash IF/ID/EX pipeline registers
- o_busy  out  1  controller not in IDLE
- o_redirect_cnt  out  CNT_W  accepted redirects, wraps

## Operation
- States: IDLE, REDIRECT, FLUSH.
- Capture condition (IDLE only): `i_ex_valid && !i_stall && (i_ex_jump_taken || i_ex_branch_taken)`.
- Target select: jump wins when both takens are high. Otherwise the branch target is used. Register `target & ~1`.
- IDLE -> REDIRECT on capture. `o_redirect_pc` loads at the same edge.
- REDIRECT: `o_redirect_valid=1`, `o_flush=1`. `o_redirect_pc` is stable until the handshake.
- Handshake is `o_redirect_valid && i_fetch_ready`. On handshake, `o_redirect_cnt` increments by 1 (wraps 2^CNT_W-1 -> 0).
  - If FLUSH_CYCLES>0: REDIRECT -> FLUSH, flush counter loads FLUSH_CYCLES-1.
  - If FLUSH_CYCLES=0: REDIRECT -> IDLE.
- FLUSH: `o_flush=1`, `o_redirect_valid=0`. The counter decrements each cycle. At 0, FLUSH -> IDLE.
- Taken inputs in REDIRECT/FLUSH are wrong-path and are ignored (no capture, no queueing).
- `i_stall` does not freeze REDIRECT or FLUSH. It only blocks capture in IDLE.
- `o_busy = (state != IDLE)`.
- In IDLE: `o_flush=0`, `o_redirect_valid=0`, and `o_redirect_pc` holds its last value.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Reset (async assert, sync-to-clk deassert use): state=IDLE, `o_redirect_valid=0`, `o_redirect_pc=0`, `o_flush=0`, `o_busy=0`, `o_redirect_cnt=0`, flush counter=0.
- Capture at edge N: `o_redirect_valid`/`o_flush` are high in cycle N+1.
- With `i_fetch_ready` high in N+1: handshake at edge N+2. `o_flush` stays high for N+2 .. N+1+FLUSH_CYCLES. IDLE is reached at N+2+FLUSH_CYCLES, and a new capture is possible at that edge.
- Total flush length = (cycles in REDIRECT) + FLUSH_CYCLES.
- `i_fetch_ready` low holds REDIRECT indefinitely with `o_redirect_pc` unchanged.
- `rst_n` low mid-REDIRECT or mid-FLUSH: return to IDLE immediately. The pending redirect is dropped and the counter clears.

## Test plan
- Reset: with `rst_n` low, all outputs are 0. Release, idle 5 cycles -> outputs unchanged.
- Branch redirect: branch_taken=1, target 0x1000, ready=1, FLUSH_CYCLES=2 -> valid high 1 cycle with pc=0x1000, flush high 3 cycles, cnt=1, busy clears on the 4th cycle.
- Jump priority and alignment: jump target 0x2003 and branch target 0x3000 both taken in one cycle -> pc=0x2002.
- Backpressure: ready low 4 cycles, then high -> valid high 5 cycles with pc stable. New takens during the wait (target 0x5000) are ignored, and cnt increments once.
- Stall and gating: taken with `i_stall=1`, or with `i_ex_valid=0` -> no capture, busy=0. Taken arriving during FLUSH -> ignored.
- Counter wrap and mid-op reset: preload via 2^CNT_W redirects (CNT_W=4 build) -> cnt wraps to 0. Assert rst_n in REDIRECT -> valid/flush drop immediately, cnt=0.
